// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encodings and sizing helpers for the stopwatch controller
//
// Purpose: state codes (identical to the ssLED status codes), the default
// clock frequency and the prescaler width calculation.
// Ports: none (package).

package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_RUN   = 2'd2,
        ST_MODE  = 2'd3
    } state_t;

    localparam int CLK_HZ_DEFAULT = 50_000_000;

    // Bits needed to count 0 .. clk_hz/tick_hz-1; never less than one bit.
    function automatic int presc_width(input int clk_hz, input int tick_hz);
        int div;
        div = clk_hz / tick_hz;
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronizer and stability-counter debouncer for one active-low key
//
// Purpose: turns a raw active-low push key into a single one-cycle press pulse
// per accepted press. Releases produce no pulse; glitches shorter than
// DEBOUNCE_CYC cycles are ignored.
// Ports:
//   CLOCK_50  in   system clock
//   RESET_N   in   asynchronous active-low reset
//   key_n     in   raw key, active-low, asynchronous to CLOCK_50
//   press     out  one-cycle pulse on an accepted 1->0 transition

module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            // cnt measures how long sync2 has disagreed with the accepted level;
            // any agreement restarts the measurement.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - key debouncing, IDLE/PAUSE/RUN/MODE sequencing and gated tick generation
//
// Purpose: front end for the BCD digit chain; produces the count-enable tick
// and the clear pulse from two debounced push keys.
// Ports:
//   CLOCK_50  in   system clock
//   RESET_N   in   asynchronous active-low reset
//   KEY[1:0]  in   raw active-low keys; KEY[0]=start/stop, KEY[1]=clear/mode
//   run_en    out  high in RUN and MODE
//   tick      out  one-cycle count enable at TICK_HZ while run_en
//   clr       out  one-cycle clear pulse on PAUSE -> IDLE
//   mode      out  high in MODE
//   ssLED     out  state code for the status LEDs

module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ       = CLK_HZ_DEFAULT,
    parameter int TICK_HZ      = 1,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [1:0] KEY,
    output logic       run_en,
    output logic       tick,
    output logic       clr,
    output logic       mode,
    output logic [1:0] ssLED
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = presc_width(CLK_HZ, TICK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    state_t        state;
    state_t        nxt;
    logic [PW-1:0] presc;
    logic          p0;
    logic          p1;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key0 (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .key_n    (KEY[0]),
        .press    (p0)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key1 (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .key_n    (KEY[1]),
        .press    (p1)
    );

    // Start/stop takes priority: a simultaneous clear/mode press is dropped.
    always_comb begin
        nxt = state;
        if (p0) begin
            case (state)
                ST_IDLE:  nxt = ST_RUN;
                ST_RUN:   nxt = ST_PAUSE;
                ST_PAUSE: nxt = ST_RUN;
                ST_MODE:  nxt = ST_PAUSE;
                default:  nxt = ST_IDLE;
            endcase
        end else if (p1) begin
            case (state)
                ST_RUN:   nxt = ST_MODE;
                ST_PAUSE: nxt = ST_IDLE;
                ST_MODE:  nxt = ST_RUN;
                default:  nxt = state;
            endcase
        end
    end

    // Tick is decoded from registers only, so it cannot coincide with clr
    // (clr fires on the way out of PAUSE, where run_en is already low).
    assign tick = run_en & (presc == PRESC_MAX);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            ssLED  <= 2'b00;
            run_en <= 1'b0;
            mode   <= 1'b0;
            clr    <= 1'b0;
            presc  <= '0;
        end else begin
            state  <= nxt;
            ssLED  <= nxt;
            run_en <= (nxt == ST_RUN) || (nxt == ST_MODE);
            mode   <= (nxt == ST_MODE);
            clr    <= (state == ST_PAUSE) && (nxt == ST_IDLE);
            // Prescaler holds while paused so a resume keeps the partial second.
            if ((state == ST_PAUSE) && (nxt == ST_IDLE)) begin
                presc <= '0;
            end else if (run_en) begin
                presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl with a cycle-level reference model

module tb_stopwatch_ctrl;

    localparam int CLK_HZ  = 100;
    localparam int TICK_HZ = 1;
    localparam int DB      = 4;
    localparam int PERIOD  = CLK_HZ / TICK_HZ;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic [1:0] KEY      = 2'b11;
    logic       run_en;
    logic       tick;
    logic       clr;
    logic       mode;
    logic [1:0] ssLED;

    stopwatch_ctrl #(
        .CLK_HZ       (CLK_HZ),
        .TICK_HZ      (TICK_HZ),
        .DEBOUNCE_CYC (DB)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY      (KEY),
        .run_en   (run_en),
        .tick     (tick),
        .clr      (clr),
        .mode     (mode),
        .ssLED    (ssLED)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int errors = 0;
    int checks = 0;

    // Reference model: state as a number 0..3 (IDLE, PAUSE, RUN, MODE),
    // running time as a plain count of timing cycles since the last clear.
    logic [1:0]  m_state;
    logic [1:0]  m_acc;
    logic [1:0]  m_press;
    logic        m_clr;
    longint      m_elapsed;
    logic [1:0]  hist[$];

    int cyc = 0;
    int tick_count = 0;
    int clr_count = 0;
    int last_tick = -1;
    int last_gap = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_run();
        return (m_state == 2'd2) || (m_state == 2'd3);
    endfunction

    task automatic model_reset();
        m_state   = 2'd0;
        m_acc     = 2'b11;
        m_press   = 2'b00;
        m_clr     = 1'b0;
        m_elapsed = 0;
        hist.delete();
        for (int i = 0; i < DB + 2; i++) hist.push_back(2'b11);
    endtask

    // One clock edge of the specified behaviour, with k the key levels at that edge.
    task automatic model_edge(input logic [1:0] k);
        logic [1:0] p;
        logic       stable;
        p = m_press;
        if (m_run()) m_elapsed++;
        m_clr = 1'b0;
        if (p[0]) begin
            case (m_state)
                2'd0:    m_state = 2'd2;
                2'd2:    m_state = 2'd1;
                2'd1:    m_state = 2'd2;
                default: m_state = 2'd1;
            endcase
        end else if (p[1]) begin
            case (m_state)
                2'd2: m_state = 2'd3;
                2'd3: m_state = 2'd2;
                2'd1: begin m_state = 2'd0; m_clr = 1'b1; m_elapsed = 0; end
                default: ;
            endcase
        end
        hist.push_back(k);
        void'(hist.pop_front());
        // A key is accepted once it has shown the new level for DB samples,
        // seen through the two-cycle synchronizer delay.
        for (int i = 0; i < 2; i++) begin
            stable = 1'b1;
            for (int j = 2; j <= DB + 1; j++)
                if (hist[hist.size() - 1 - j][i] == m_acc[i]) stable = 1'b0;
            m_press[i] = 1'b0;
            if (stable) begin
                m_acc[i]   = ~m_acc[i];
                m_press[i] = ~m_acc[i];
            end
        end
    endtask

    task automatic step();
        logic exp_tick;
        @(posedge CLOCK_50);
        model_edge(KEY);
        @(negedge CLOCK_50);
        cyc++;
        exp_tick = m_run() && ((m_elapsed % PERIOD) == PERIOD - 1);
        chk("outputs{ssLED,run_en,mode,clr,tick}",
            {27'd0, ssLED, run_en, mode, clr, tick},
            {27'd0, m_state, m_run(), (m_state == 2'd3), m_clr, exp_tick});
        if (tick) begin
            if (last_tick >= 0) last_gap = cyc - last_tick;
            last_tick = cyc;
            tick_count++;
        end
        if (clr) clr_count++;
    endtask

    task automatic press(input int k, input int hold);
        KEY[k] = 1'b0;
        repeat (hold) step();
        KEY[k] = 1'b1;
        repeat (DB + 4) step();
    endtask

    // Presses start/stop from PAUSE/IDLE, then checks the distance from the
    // run_en rise to the first tick against the model's stored running time.
    task automatic first_tick_gap(input string tag, output int gap);
        int found;
        int rise;
        int exp_gap;
        gap = -1;
        KEY[0] = 1'b0;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            if (run_en) found = 1;
        end
        chk({tag, "_rise_seen"}, found, 1);
        rise = cyc;
        exp_gap = PERIOD - int'(m_elapsed % PERIOD);
        for (int n = 0; n < PERIOD + 20 && !tick; n++) begin
            step();
            if (n == DB + 2) KEY[0] = 1'b1;
        end
        KEY[0] = 1'b1;
        gap = cyc - rise + 1;
        chk({tag, "_gap"}, gap, exp_gap);
        repeat (DB + 4) step();
    endtask

    initial begin
        int gap;
        int found;
        int k;
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        chk("reset_outputs", {ssLED, run_en, tick, clr, mode}, 6'd0);
        RESET_N = 1'b1;

        // 1. idle with keys released
        repeat (50) step();
        chk("idle_ssLED", ssLED, 2'd0);
        chk("idle_tick_count", tick_count, 0);
        chk("idle_clr_count", clr_count, 0);

        // 2. start from IDLE: ssLED changes exactly one cycle after the press pulse
        KEY[0] = 1'b0;
        repeat (6) step();
        chk("before_accept_ssLED", ssLED, 2'd0);
        step();
        chk("run_ssLED", ssLED, 2'd2);
        repeat (3) step();
        KEY[0] = 1'b1;
        tick_count = 0;
        last_tick = -1;
        repeat (250) step();
        chk("run_tick_period", last_gap, PERIOD);
        chk("run_ticks_seen", tick_count >= 2, 1);
        chk("single_press_still_run", ssLED, 2'd2);

        // 3. bounce shorter than the debounce window
        for (int i = 0; i < 10; i++) begin
            KEY[0] = ~KEY[0];
            repeat (2) step();
        end
        KEY[0] = 1'b1;
        repeat (10) step();
        chk("bounce_ignored", ssLED, 2'd2);

        // 4. pause keeps the fractional second
        repeat ($urandom_range(40, 160)) step();
        press(0, 8);
        chk("pause_ssLED", ssLED, 2'd1);
        tick_count = 0;
        repeat (500) step();
        chk("pause_no_tick", tick_count, 0);
        first_tick_gap("resume", gap);

        // 5. clear from PAUSE, then mode from RUN
        press(0, 8);
        chk("pause2_ssLED", ssLED, 2'd1);
        KEY[1] = 1'b0;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            if (clr) found = 1;
        end
        chk("clr_seen", found, 1);
        chk("clear_ssLED", ssLED, 2'd0);
        step();
        chk("clr_one_cycle", clr, 1'b0);
        KEY[1] = 1'b1;
        repeat (DB + 4) step();
        first_tick_gap("after_clear", gap);
        chk("after_clear_full_period", gap, PERIOD);
        press(1, 6);
        chk("mode_ssLED", ssLED, 2'd3);
        chk("mode_flag", mode, 1'b1);
        tick_count = 0;
        last_tick = -1;
        repeat (220) step();
        chk("mode_tick_period", last_gap, PERIOD);

        // 6. corner cases
        press(1, 6);
        chk("mode_to_run", ssLED, 2'd2);
        KEY = 2'b00;
        repeat (8) step();
        KEY = 2'b11;
        repeat (DB + 4) step();
        chk("both_keys_p0_wins", ssLED, 2'd1);
        press(0, 6);
        repeat ($urandom_range(10, 90)) step();
        #2 RESET_N = 1'b0;
        #1;
        chk("async_reset_outputs", {ssLED, run_en, tick, clr, mode}, 6'd0);
        model_reset();
        repeat (3) @(negedge CLOCK_50);
        chk("reset_held_outputs", {ssLED, run_en, tick, clr, mode}, 6'd0);
        RESET_N = 1'b1;
        repeat (20) step();
        chk("after_reset_idle", ssLED, 2'd0);

        // random key activity against the model
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 2);
            if (k == 2) KEY = 2'b00;
            else KEY[k] = 1'b0;
            repeat ($urandom_range(1, 12)) step();
            KEY = 2'b11;
            repeat ($urandom_range(0, 120)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
